mips_dbus_port: RTL and testbench

Data-bus responder for the MIPS I core: answers the core's data address, byte-write-enable, write-data and read-enable lines with a single-cycle word RAM plus a small memory-mapped I/O window. The I/O window holds a 4-entry byte transmit FIFO with a valid/ready output handshake and an optional cycle timer with compare interrupt. It sits beside the core at the top level, on the other end of the core's data port.

---
 rtl/mips_dbus_port.sv | 157 +++++++++++++++
 tb/tb_mips_dbus_port.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_dbus_port.sv
// mips_dbus_port: data-bus responder for the MIPS I core.
// Serves a single-cycle word RAM (DA[31]=0) and a small I/O window (DA[31]=1):
//   reg 0 STATUS, reg 1 TXDATA (4-byte transmit FIFO), reg 2 COUNT, reg 3 COMPARE.
// Optional feature macro: MIPS_DBUS_TIMER_EN builds the cycle timer and compare
// interrupt; without it COUNT/COMPARE read 0, ignore writes, and irq is tied low.
module mips_dbus_port #(
    parameter int AW = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] DA,
    input  logic [3:0]  we,
    input  logic [31:0] DO,
    input  logic        re,
    output logic [31:0] DI,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        irq
);

    // Replace only the byte lanes enabled in w.
    function automatic logic [31:0] lane_merge(input logic [31:0] old,
                                               input logic [31:0] dat,
                                               input logic [3:0]  w);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (w[i]) r[8*i +: 8] = dat[8*i +: 8];
        return r;
    endfunction

    // ---------------- decode ----------------
    logic          io_sel;
    logic [1:0]    reg_idx;
    logic [AW-1:0] word_idx;
    logic          any_we;

    assign io_sel   = DA[31];
    assign reg_idx  = DA[3:2];
    assign word_idx = DA[AW+1:2];
    assign any_we   = |we;

    // Address bits that the decode deliberately ignores (aliasing).
    logic unused_addr;
    assign unused_addr = ^{DA[30:AW+2], DA[1:0]};

    logic stat_wr, push, cnt_wr, cmp_wr;
    assign stat_wr = io_sel && (reg_idx == 2'd0) && we[0];
    assign push    = io_sel && (reg_idx == 2'd1) && we[0];
    assign cnt_wr  = io_sel && (reg_idx == 2'd2) && any_we;
    assign cmp_wr  = io_sel && (reg_idx == 2'd3) && any_we;

    // ---------------- RAM ----------------
    logic [31:0] mem [0:(1<<AW)-1];

    // Per-lane synchronous write; contents are not touched by reset.
    always_ff @(posedge clock) begin
        if (!io_sel)
            for (int i = 0; i < 4; i++)
                if (we[i]) mem[word_idx][8*i +: 8] <= DO[8*i +: 8];
    end

    // ---------------- transmit FIFO ----------------
    logic [7:0] fifo [0:3];
    logic [1:0] rd_ptr, wr_ptr;
    logic [2:0] fifo_cnt;
    logic       full, empty, pop, push_ok, overflow;

    assign full    = (fifo_cnt == 3'd4);
    assign empty   = (fifo_cnt == 3'd0);
    assign pop     = tx_valid && tx_ready;
    // A pop in the same cycle frees the slot the push needs.
    assign push_ok = push && (!full || pop);

    assign tx_valid = !empty;
    assign tx_data  = empty ? 8'h00 : fifo[rd_ptr];

    // Pointer/count bookkeeping and storage; reset empties the queue at once.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
            for (int i = 0; i < 4; i++) fifo[i] <= '0;
        end else begin
            if (pop) rd_ptr <= rd_ptr + 2'd1;
            if (push_ok) begin
                fifo[wr_ptr] <= DO[7:0];
                wr_ptr       <= wr_ptr + 2'd1;
            end
            case ({push_ok, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Sticky overflow: set by a dropped push, cleared by STATUS write with DO[3].
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            overflow <= 1'b0;
        else if (push && !push_ok)
            overflow <= 1'b1;
        else if (stat_wr && DO[3])
            overflow <= 1'b0;
    end

    // ---------------- timer ----------------
    logic [31:0] count_q, compare_q;
    logic        flag_q;

`ifdef MIPS_DBUS_TIMER_EN
    // Free-running counter, lane writes, and compare flag (COMPARE write wins).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q   <= '0;
            compare_q <= 32'hFFFF_FFFF;
            flag_q    <= 1'b0;
        end else begin
            if (cnt_wr) count_q <= lane_merge(count_q, DO, we);
            else        count_q <= count_q + 32'd1;
            if (cmp_wr) compare_q <= lane_merge(compare_q, DO, we);
            if (cmp_wr) flag_q <= 1'b0;
            else if (count_q == compare_q) flag_q <= 1'b1;
        end
    end
`else
    logic unused_tmr;
    assign unused_tmr = cnt_wr ^ cmp_wr;
    assign count_q    = '0;
    assign compare_q  = '0;
    assign flag_q     = 1'b0;
`endif

    assign irq = flag_q;

    // ---------------- read mux ----------------
    // Zero-latency read; same-cycle write to the same word still returns old data.
    always_comb begin
        DI = '0;
        if (re) begin
            if (!io_sel) begin
                DI = mem[word_idx];
            end else begin
                case (reg_idx)
                    2'd0:    DI = {28'd0, overflow, flag_q, empty, !full};
                    2'd2:    DI = count_q;
                    2'd3:    DI = compare_q;
                    default: DI = '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mips_dbus_port.sv
// Self-checking bench for mips_dbus_port: directed steps from the block's
// test plan followed by a randomized phase, all compared against a
// transaction-level model (word map, byte queue, plain integer timer).
module tb_mips_dbus_port;
    localparam int AW = 10;

    logic        clock, reset;
    logic [31:0] DA, DO, DI;
    logic [3:0]  we;
    logic        re, tx_ready, tx_valid, irq;
    logic [7:0]  tx_data;

    mips_dbus_port #(.AW(AW)) dut (
        .clock(clock), .reset(reset), .DA(DA), .we(we), .DO(DO), .re(re),
        .DI(DI), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .irq(irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_ram [int];
    logic [7:0]  m_q [$];
    logic        m_ovf, m_flag;
    logic [31:0] m_cnt, m_cmp;

    logic [31:0] last_di;
    logic [7:0]  last_tx;
    logic        last_v, last_irq;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lanes(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] w);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (w[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_ovf  = 1'b0;
        m_flag = 1'b0;
        m_cnt  = 32'd0;
`ifdef MIPS_DBUS_TIMER_EN
        m_cmp  = 32'hFFFF_FFFF;
`else
        m_cmp  = 32'd0;
`endif
    endtask

    function automatic bit di_known(input logic [31:0] a, input logic r);
        if (!r || a[31]) return 1'b1;
        return m_ram.exists(int'(a[AW+1:2]));
    endfunction

    function automatic logic [31:0] model_di(input logic [31:0] a, input logic r);
        if (!r) return 32'd0;
        if (!a[31]) return m_ram[int'(a[AW+1:2])];
        case (a[3:2])
            2'd0:    return {28'd0, m_ovf, m_flag, m_q.size() == 0, m_q.size() < 4};
            2'd2:    return m_cnt;
            2'd3:    return m_cmp;
            default: return 32'd0;
        endcase
    endfunction

    // Apply one rising edge's worth of effects to the model.
    task automatic model_edge(input logic [31:0] a, input logic [3:0] w,
                              input logic [31:0] d, input logic rdy);
        int  idx;
        bit  pop, full;
        idx  = int'(a[AW+1:2]);
        pop  = (m_q.size() != 0) && rdy;
        full = (m_q.size() == 4);
        if (!a[31] && w != 4'd0) begin
            if (m_ram.exists(idx)) m_ram[idx] = lanes(m_ram[idx], d, w);
            else if (w == 4'hF)    m_ram[idx] = d;
        end
        if (a[31] && a[3:2] == 2'd0 && w[0] && d[3]) m_ovf = 1'b0;
        if (pop) void'(m_q.pop_front());
        if (a[31] && a[3:2] == 2'd1 && w[0]) begin
            if (!full || pop) m_q.push_back(d[7:0]);
            else              m_ovf = 1'b1;
        end
`ifdef MIPS_DBUS_TIMER_EN
        begin
            bit cw, kw;
            cw = a[31] && a[3:2] == 2'd3 && w != 4'd0;
            kw = a[31] && a[3:2] == 2'd2 && w != 4'd0;
            m_flag = cw ? 1'b0 : (m_flag || m_cnt == m_cmp);
            m_cnt  = kw ? lanes(m_cnt, d, w) : m_cnt + 32'd1;
            if (cw) m_cmp = lanes(m_cmp, d, w);
        end
`endif
    endtask

    // One bus cycle: drive at negedge, check combinational outputs, take the edge.
    task automatic cyc(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d,
                       input logic r, input logic rdy);
        @(negedge clock);
        DA = a; we = w; DO = d; re = r; tx_ready = rdy;
        #1;
        chk("tx_valid", {31'd0, tx_valid}, {31'd0, m_q.size() != 0});
        chk("tx_data", {24'd0, tx_data}, {24'd0, (m_q.size() != 0) ? m_q[0] : 8'h00});
        chk("irq", {31'd0, irq}, {31'd0, m_flag});
        if (di_known(a, r)) chk("DI", DI, model_di(a, r));
        last_di = DI; last_tx = tx_data; last_v = tx_valid; last_irq = irq;
        model_edge(a, w, d, rdy);
        @(posedge clock);
    endtask

    localparam logic [31:0] ST = 32'h8000_0000, TX = 32'h8000_0004,
                            CN = 32'h8000_0008, CP = 32'h8000_000C;

    initial begin
        logic [31:0] a, d;
        logic [3:0]  w;
        logic        r, rdy;
        int          op;

        DA = '0; we = '0; DO = '0; re = 1'b0; tx_ready = 1'b0;
        reset = 1'b0;
        model_reset();
        repeat (3) @(posedge clock);
        @(negedge clock); #1;
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        reset = 1'b1;
        @(posedge clock);
        model_edge('0, '0, '0, 1'b0);

        cyc(ST, 4'h0, 0, 1, 0);
        chk("rst_status", last_di, 32'h3);

        // RAM lane writes
        cyc(32'h10, 4'hF, 32'h1122_3344, 0, 0);
        cyc(32'h10, 4'b0010, 32'h0000_AA00, 0, 0);
        cyc(32'h10, 4'h0, 0, 1, 0);
        chk("ram_lanes", last_di, 32'h1122_AA44);
        cyc(32'h10, 4'h0, 0, 0, 0);
        chk("ram_re0", last_di, 32'h0);

        // FIFO fill and overflow
        for (int i = 0; i < 5; i++) cyc(TX, 4'h1, 32'h41 + i, 0, 0);
        cyc(ST, 4'h0, 0, 1, 0);
        chk("status_full_ovf", last_di, 32'h8);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 4'h0, 0, 0, 1);
            chk("drain_fill", {24'd0, last_tx}, 32'h41 + i);
        end
        cyc(ST, 4'h0, 0, 1, 0);
        chk("drained_valid", {31'd0, last_v}, 32'd0);
        chk("status_empty_ovf", last_di, 32'hB);
        cyc(ST, 4'h1, 32'h8, 0, 0);

        // Push into a full FIFO with a simultaneous pop
        for (int i = 0; i < 4; i++) cyc(TX, 4'h1, 32'h61 + i, 0, 0);
        cyc(TX, 4'h1, 32'h55, 0, 1);
        cyc(ST, 4'h0, 0, 1, 0);
        chk("status_full_nopop_ovf", last_di, 32'h0);
        cyc(0, 4'h0, 0, 0, 1); chk("pp0", {24'd0, last_tx}, 32'h62);
        cyc(0, 4'h0, 0, 0, 1); chk("pp1", {24'd0, last_tx}, 32'h63);
        cyc(0, 4'h0, 0, 0, 1); chk("pp2", {24'd0, last_tx}, 32'h64);
        cyc(0, 4'h0, 0, 0, 1); chk("pp3", {24'd0, last_tx}, 32'h55);
        cyc(0, 4'h0, 0, 0, 0); chk("pp_empty", {31'd0, last_v}, 32'd0);

        // Timer compare
        cyc(CP, 4'hF, 32'd20, 0, 0);
        cyc(CN, 4'hF, 32'd10, 0, 0);
        repeat (10) cyc(0, 4'h0, 0, 0, 0);
        cyc(0, 4'h0, 0, 0, 0);
        chk("irq_before", {31'd0, last_irq}, 32'd0);
        cyc(0, 4'h0, 0, 0, 0);
`ifdef MIPS_DBUS_TIMER_EN
        chk("irq_rise", {31'd0, last_irq}, 32'd1);
`else
        chk("irq_off", {31'd0, last_irq}, 32'd0);
`endif
        cyc(CP, 4'hF, 32'd100, 0, 0);
        cyc(0, 4'h0, 0, 0, 0);
        chk("irq_clear", {31'd0, last_irq}, 32'd0);

        // Counter wrap
        cyc(CN, 4'hF, 32'hFFFF_FFFE, 0, 0);
        cyc(CN, 4'h0, 0, 1, 0);
        cyc(CN, 4'h0, 0, 1, 0);
`ifdef MIPS_DBUS_TIMER_EN
        chk("wrap_ff", last_di, 32'hFFFF_FFFF);
`else
        chk("count_off", last_di, 32'h0);
`endif
        cyc(CN, 4'h0, 0, 1, 0);
        chk("wrap_00", last_di, 32'h0);

        // Asynchronous reset with bytes queued and a handshake in flight
        for (int i = 0; i < 3; i++) cyc(TX, 4'h1, 32'h71 + i, 0, 0);
        @(negedge clock);
        DA = '0; we = '0; DO = '0; re = 1'b0; tx_ready = 1'b1;
        reset = 1'b0;
        #1;
        chk("async_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("async_tx_data", {24'd0, tx_data}, 32'd0);
        #2;
        tx_ready = 1'b0;
        reset = 1'b1;
        model_reset();
        @(posedge clock);
        model_edge('0, '0, '0, 1'b0);
        cyc(32'h10, 4'h0, 0, 1, 0);
        chk("ram_survives", last_di, 32'h1122_AA44);
        cyc(ST, 4'h0, 0, 1, 0);
        chk("status_after_rst", last_di, 32'h3);

        // Randomized phase over 8 words (aliased through upper address bits)
        for (int i = 0; i < 8; i++) cyc(32'(i) << 2, 4'hF, $urandom, 0, 0);
        for (int n = 0; n < 400; n++) begin
            op  = int'($urandom_range(0, 7));
            rdy = 1'($urandom_range(0, 1));
            r   = 1'($urandom_range(0, 1));
            d   = $urandom;
            w   = 4'h0;
            case (op)
                0, 1: begin
                    a = ($urandom & 32'h7FFF_F000) | (32'($urandom_range(0, 7)) << 2);
                    w = 4'($urandom_range(1, 15));
                end
                2: a = ($urandom & 32'h7FFF_F000) | (32'($urandom_range(0, 7)) << 2);
                3, 4: begin
                    a = TX | ($urandom & 32'h7FFF_FFF0);
                    w = 4'($urandom_range(0, 15));
                end
                5: begin
                    a = ST | ($urandom & 32'h7FFF_FFF0);
                    if ($urandom_range(0, 3) == 0) w = 4'($urandom_range(1, 15));
                end
                6: begin
                    a = (($urandom_range(0, 1) == 1) ? CN : CP) | ($urandom & 32'h7FFF_FFF0);
                    if ($urandom_range(0, 5) == 0) w = 4'($urandom_range(1, 15));
                end
                default: a = 32'h0;
            endcase
            cyc(a, w, d, r, rdy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
